load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 resetn  in  1  synchronous active-low reset, sampled on rising clk.
REQ-003 req_valid  in  1  core requests a load/store.
REQ-004 req_ready  out  1  unit can accept a request this cycle.
REQ-005 req_is_store  in  1  1=store, 0=load.
REQ-006 req_funct3  in  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-aligned.
REQ-009 rsp_valid  out  1  one-cycle pulse: request completed.
REQ-010 rsp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-011 rsp_err  out  1  misaligned or illegal funct3; qualified by rsp_valid.
REQ-012 mem_addr  out  32  word address to memory, bits[1:0] forced 0.
REQ-013 mem_rdata  in  32  memory read data, valid the cycle after mem_rstrb.
REQ-014 mem_rstrb  out  1  read strobe.
REQ-015 mem_wdata  out  32  lane-replicated store data.
REQ-016 mem_wmask  out  4  byte-lane write enables; bit i writes bits[8i+7:8i].

Function
REQ-017 States: IDLE, ISSUE, LOAD_WAIT, RESP; all outputs registered.
REQ-018 Accept when req_valid&&req_ready; req_ready=1 only in IDLE and RESP.
REQ-019 On accept: latch is_store, funct3, addr, wdata; next state ISSUE, or RESP with rsp_err=1 if illegal.
REQ-020 Illegal: load funct3 in {3,6,7}; store funct3>=3; LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1.
REQ-021 Illegal requests shall never assert mem_rstrb or a nonzero mem_wmask.
REQ-022 ISSUE: mem_addr={addr[31:2],2'b00}; for a load, mem_rstrb=1 and mem_wmask=0; for a store, mem_rstrb=0.
REQ-023 ISSUE store: SB wdata={4{b[7:0]}}, mask=4'b0001<<addr[1:0]; SH wdata={2{h[15:0]}}, mask=4'b0011<<{addr[1],1'b0}; SW wdata=wdata, mask=4'b1111.
REQ-024 ISSUE next state: loads go to LOAD_WAIT, stores go to RESP.
REQ-025 In every other state, mem_rstrb=0 and mem_wmask=0 (exactly one strobe cycle per request).
REQ-026 LOAD_WAIT: capture mem_rdata; select byte addr[1:0] or half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; next state RESP.
REQ-027 RESP: rsp_valid=1 for exactly one cycle; rsp_rdata/rsp_err held only in this cycle, otherwise 0.
REQ-028 RESP: a new accept goes to ISSUE; otherwise go to IDLE.
REQ-029 Latency from accept to rsp_valid: load 3 cycles, store 2 cycles, error 1 cycle.
REQ-030 req_valid in ISSUE/LOAD_WAIT is ignored; the core holds it until ready.

Reset
REQ-031 resetn low at a rising edge -> state IDLE; rsp_valid, rsp_err, mem_rstrb=0; mem_wmask=0; rsp_rdata, mem_addr, mem_wdata=0.
REQ-032 Reset asserted during ISSUE aborts the access: strobes are 0 from the next cycle and no rsp_valid is produced.
REQ-033 req_ready=1 in the first cycle after resetn is deasserted.

Structure
REQ-034 Shared package lsu_pkg holds funct3 constants and the state enum.
REQ-035 Sub-module lsu_align (combinational) holds store lane replication/mask and load extraction/extension; all registers stay in the top module.

Verification
REQ-036 SB addr=0x103 data=0x000000AB -> ISSUE mem_addr=0x100, wmask=4'b1000, wdata=0xABABABAB; rsp_valid 2 cycles after accept.
REQ-037 LB addr=0x102, mem_rdata=0x12F45678 -> rsp_rdata=0xFFFFFFF4; LBU same -> 0x000000F4; rsp_valid 3 cycles after accept.
REQ-038 LH addr=0x201 -> rsp_err=1 the cycle after accept; mem_rstrb and mem_wmask stay 0.
REQ-039 SH addr=0x202 data=0xBEEF, then LHU addr=0x202 against the memory model -> 0x0000BEEF; second accept in the RESP cycle.
REQ-040 resetn low during ISSUE of SW -> no rsp_valid, mem_wmask=0 the next cycle, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - controller state enumeration
//   - is_illegal(): decides whether a request may touch memory at all
package lsu_pkg;

    // Load encodings (stores share the low three: SB=0, SH=1, SW=2).
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_LOAD_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    // An illegal request is answered with rsp_err and never reaches memory.
    function automatic logic is_illegal(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (is_store) begin
            if (funct3 > F3_W) begin
                bad = 1'b1;
            end
        end else begin
            if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
                bad = 1'b1;
            end
        end
        if (funct3 == F3_W && addr_lo != 2'b00) begin
            bad = 1'b1;
        end
        if ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   Ports:
//     funct3     in  3   access size / signedness
//     addr_lo    in  2   byte offset within the word
//     wdata      in  32  right-aligned store data
//     rdata      in  32  raw memory word for a load
//     store_data out 32  store data replicated into every lane it can occupy
//     store_mask out 4   byte-lane write enables for the store
//     load_data  out 32  selected and extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] store_data,
    output logic [3:0]  store_mask,
    output logic [31:0] load_data
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    // Replicating the data lets the mask alone pick the destination lane.
    always_comb begin
        store_data = wdata;
        store_mask = 4'b1111;
        case (funct3[1:0])
            2'd0: begin
                store_data = {4{wdata[7:0]}};
                store_mask = 4'b0001 << addr_lo;
            end
            2'd1: begin
                store_data = {2{wdata[15:0]}};
                store_mask = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                store_data = wdata;
                store_mask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time from the core,
// performs a single-strobe memory access and returns one response pulse.
//   Ports:
//     clk, resetn        clock, synchronous active-low reset
//     req_valid/ready    request handshake (ready only in IDLE and RESP)
//     req_is_store       1 = store, 0 = load
//     req_funct3         RV32I funct3
//     req_addr           byte address
//     req_wdata          right-aligned store data
//     rsp_valid          one-cycle completion pulse
//     rsp_rdata          extended load data (0 for stores/errors)
//     rsp_err            misaligned or illegal funct3
//     mem_addr           word-aligned memory address
//     mem_rdata          memory data, valid the cycle after mem_rstrb
//     mem_rstrb          read strobe
//     mem_wdata          lane-replicated store data
//     mem_wmask          byte-lane write enables
// Latency accept -> rsp_valid: load 3, store 2, error 1 cycle.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask
);

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accepting;
    logic        accept;
    logic        illegal;
    logic        is_store_sel;
    logic [2:0]  funct3_sel;
    logic [31:0] addr_sel;
    logic [31:0] wdata_sel;
    logic [31:0] store_data;
    logic [3:0]  store_mask;
    logic [31:0] load_data;

    // In the accepting states the ISSUE outputs are computed from the live
    // request so they can be registered on the accept edge; elsewhere the
    // aligner works on the latched request (load extraction in LOAD_WAIT).
    assign accepting    = (state == ST_IDLE) || (state == ST_RESP);
    assign accept       = req_valid && req_ready;
    assign is_store_sel = accepting ? req_is_store : is_store_q;
    assign funct3_sel   = accepting ? req_funct3   : funct3_q;
    assign addr_sel     = accepting ? req_addr     : addr_q;
    assign wdata_sel    = accepting ? req_wdata    : wdata_q;
    assign illegal      = is_illegal(is_store_sel, funct3_sel, addr_sel[1:0]);

    lsu_align u_align (
        .funct3     (funct3_sel),
        .addr_lo    (addr_sel[1:0]),
        .wdata      (wdata_sel),
        .rdata      (mem_rdata),
        .store_data (store_data),
        .store_mask (store_mask),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'd0;
            mem_addr   <= 32'd0;
            mem_rstrb  <= 1'b0;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 4'd0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            // Strobes and response fields are single-cycle by default.
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_rstrb <= 1'b0;
            mem_wmask <= 4'd0;

            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        if (illegal) begin
                            state     <= ST_RESP;
                            req_ready <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            req_ready <= 1'b0;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_rstrb <= !req_is_store;
                            if (req_is_store) begin
                                mem_wmask <= store_mask;
                                mem_wdata <= store_data;
                            end
                        end
                    end else begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (is_store_q) begin
                        state     <= ST_RESP;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        state     <= ST_LOAD_WAIT;
                        req_ready <= 1'b0;
                    end
                end
                ST_LOAD_WAIT: begin
                    state     <= ST_RESP;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
